// File: rtl/game_flow_ctrl.sv
// -----------------------------------------------------------------------------
// game_flow_ctrl
//
// Game-flow sequencer for the duck-shooting VGA game. It walks through
// IDLE -> WAIT -> GAME (<-> PAUSE) -> SCORE. Play runs for ROUNDS rounds of
// GAME_TIME seconds each, with the seconds derived from a CLK_HZ prescaler.
// It also keeps a saturating hit score, returns to IDLE after WAIT_TIMEOUT
// idle seconds in WAIT, drives the play-button rectangle and selects the
// per-screen colour.
//
// Ports
//   pclk, rst_n            pixel clock, asynchronous active-low reset
//   rect_clicked_play      level, click inside the play button
//   uart_start             level, remote player ready
//   mouse_clicked_stop     level, click on the score screen
//   duck_hit               pulse, duck shot (counted only in GAME)
//   pause_toggle           pulse, pause / resume request
//   rgb_in_*               per-screen pixel colour (12 bit)
//   state                  IDLE=0 WAIT=1 GAME=2 PAUSE=3 SCORE=4
//   btn_*                  play-button rectangle, zero while not in IDLE
//   btn_active             button drawn and clickable
//   rgb_out                selected pixel (follows the registered state)
//   time_left              seconds remaining in the current round
//   round                  0-based round index
//   score                  hit count, saturating
//   game_over              one-cycle pulse on GAME -> SCORE
// -----------------------------------------------------------------------------
module game_flow_ctrl #(
  parameter int          CLK_HZ       = 65_000_000,
  parameter int          GAME_TIME    = 60,
  parameter int          ROUNDS       = 3,
  parameter int          WAIT_TIMEOUT = 30,
  parameter logic [10:0] BTN_X        = 11'd380,
  parameter logic [10:0] BTN_Y        = 11'd186,
  parameter logic [10:0] BTN_W        = 11'd300,
  parameter logic [10:0] BTN_H        = 11'd100
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        rect_clicked_play,
  input  logic        uart_start,
  input  logic        mouse_clicked_stop,
  input  logic        duck_hit,
  input  logic        pause_toggle,
  input  logic [11:0] rgb_in_play,
  input  logic [11:0] rgb_in_wait,
  input  logic [11:0] rgb_in_game,
  input  logic [11:0] rgb_in_pause,
  input  logic [11:0] rgb_in_score,
  output logic [2:0]  state,
  output logic [10:0] btn_hstart,
  output logic [10:0] btn_vstart,
  output logic [10:0] btn_hlength,
  output logic [10:0] btn_vlength,
  output logic        btn_active,
  output logic [11:0] rgb_out,
  output logic [7:0]  time_left,
  output logic [3:0]  round,
  output logic [15:0] score,
  output logic        game_over
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_GAME  = 3'd2,
    S_PAUSE = 3'd3,
    S_SCORE = 3'd4
  } state_t;

  localparam int              PW         = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0]   PRESC_MAX  = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0]   PRESC_ONE  = PW'(1);
  localparam logic [7:0]      GAME_TIME_L = 8'(GAME_TIME);
  localparam logic [3:0]      LAST_ROUND = 4'(ROUNDS - 1);
  localparam logic [15:0]     WAIT_LAST  = 16'(WAIT_TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   wait_cnt_q, wait_cnt_d;
  logic [7:0]    time_left_q, time_left_d;
  logic [3:0]    round_q, round_d;
  logic [15:0]   score_q, score_d;
  logic          game_over_q, game_over_d;
  logic          btn_active_q, btn_active_d;
  logic [10:0]   btn_hstart_q, btn_hstart_d;
  logic [10:0]   btn_vstart_q, btn_vstart_d;
  logic [10:0]   btn_hlength_q, btn_hlength_d;
  logic [10:0]   btn_vlength_q, btn_vlength_d;
  logic [11:0]   rgb_out_q, rgb_out_d;
  logic          run;
  logic          tick;
  logic          pause_edge;

  always_comb begin
    state_d       = state_q;
    presc_d       = presc_q;
    wait_cnt_d    = wait_cnt_q;
    time_left_d   = time_left_q;
    round_d       = round_q;
    score_d       = score_q;
    game_over_d   = 1'b0;
    btn_active_d  = 1'b0;
    btn_hstart_d  = 11'd0;
    btn_vstart_d  = 11'd0;
    btn_hlength_d = 11'd0;
    btn_vlength_d = 11'd0;
    rgb_out_d     = 12'd0;

    run  = (state_q == S_WAIT) || (state_q == S_GAME);
    tick = run && (presc_q == PRESC_MAX);

    // Seconds prescaler: free-runs in WAIT/GAME, frozen elsewhere.
    if (run) begin
      presc_d = tick ? '0 : presc_q + PRESC_ONE;
    end

    case (state_q)
      S_IDLE: begin
        if (rect_clicked_play) begin
          state_d = S_WAIT;
          score_d = 16'd0;
          round_d = 4'd0;
        end
      end
      S_WAIT: begin
        if (tick) begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
        // A start beats a coincident timeout tick.
        if (rect_clicked_play && uart_start) begin
          state_d     = S_GAME;
          time_left_d = GAME_TIME_L;
        end else if ((WAIT_TIMEOUT != 0) && tick && (wait_cnt_q == WAIT_LAST)) begin
          state_d = S_IDLE;
        end
      end
      S_GAME: begin
        if (duck_hit && (score_q != 16'hFFFF)) begin
          score_d = score_q + 16'd1;
        end
        if (tick) begin
          if (time_left_q == 8'd1) begin
            time_left_d = 8'd0;
            if (round_q == LAST_ROUND) begin
              state_d     = S_SCORE;
              game_over_d = 1'b1;
            end else begin
              round_d = round_q + 4'd1;
              state_d = S_WAIT;
            end
          end else begin
            time_left_d = time_left_q - 8'd1;
          end
        end
        // Round expiry wins over a pause request in the same cycle.
        if (pause_toggle && (state_d == S_GAME)) begin
          state_d = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (pause_toggle) begin
          state_d = S_GAME;
        end
      end
      S_SCORE: begin
        if (mouse_clicked_stop) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        presc_d     = '0;
        wait_cnt_d  = 16'd0;
        time_left_d = 8'd0;
        round_d     = 4'd0;
        score_d     = 16'd0;
      end
    endcase

    // Any state change restarts the timing, except pause/resume, which
    // must carry the partially elapsed second across.
    pause_edge = ((state_q == S_GAME) && (state_d == S_PAUSE)) ||
                 ((state_q == S_PAUSE) && (state_d == S_GAME));
    if ((state_d != state_q) && !pause_edge) begin
      presc_d    = '0;
      wait_cnt_d = 16'd0;
    end

    // Button geometry follows the state being entered, so it is in place
    // in the same cycle the new state becomes visible.
    if (state_d == S_IDLE) begin
      btn_active_d  = 1'b1;
      btn_hstart_d  = BTN_X;
      btn_vstart_d  = BTN_Y;
      btn_hlength_d = BTN_W;
      btn_vlength_d = BTN_H;
    end

    case (state_q)
      S_IDLE:  rgb_out_d = rgb_in_play;
      S_WAIT:  rgb_out_d = rgb_in_wait;
      S_GAME:  rgb_out_d = rgb_in_game;
      S_PAUSE: rgb_out_d = rgb_in_pause;
      S_SCORE: rgb_out_d = rgb_in_score;
      default: rgb_out_d = 12'd0;
    endcase
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      presc_q       <= '0;
      wait_cnt_q    <= 16'd0;
      time_left_q   <= 8'd0;
      round_q       <= 4'd0;
      score_q       <= 16'd0;
      game_over_q   <= 1'b0;
      btn_active_q  <= 1'b1;
      btn_hstart_q  <= BTN_X;
      btn_vstart_q  <= BTN_Y;
      btn_hlength_q <= BTN_W;
      btn_vlength_q <= BTN_H;
      rgb_out_q     <= 12'd0;
    end else begin
      state_q       <= state_d;
      presc_q       <= presc_d;
      wait_cnt_q    <= wait_cnt_d;
      time_left_q   <= time_left_d;
      round_q       <= round_d;
      score_q       <= score_d;
      game_over_q   <= game_over_d;
      btn_active_q  <= btn_active_d;
      btn_hstart_q  <= btn_hstart_d;
      btn_vstart_q  <= btn_vstart_d;
      btn_hlength_q <= btn_hlength_d;
      btn_vlength_q <= btn_vlength_d;
      rgb_out_q     <= rgb_out_d;
    end
  end

  assign state       = state_q;
  assign btn_hstart  = btn_hstart_q;
  assign btn_vstart  = btn_vstart_q;
  assign btn_hlength = btn_hlength_q;
  assign btn_vlength = btn_vlength_q;
  assign btn_active  = btn_active_q;
  assign rgb_out     = rgb_out_q;
  assign time_left   = time_left_q;
  assign round       = round_q;
  assign score       = score_q;
  assign game_over   = game_over_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// -----------------------------------------------------------------------------
// tb_game_flow_ctrl
//
// Bench for game_flow_ctrl. The main instance (CLK_HZ=10, GAME_TIME=3,
// ROUNDS=2, WAIT_TIMEOUT=2) is tracked every cycle by a behavioural model that
// counts elapsed cycles per round / per wait rather than seconds ticks, and
// directed literal checks pin key points. A second instance (slow clock,
// long round, no WAIT timeout) covers WAIT persistence and score saturation.
// -----------------------------------------------------------------------------
module tb_game_flow_ctrl;

  localparam int CLK = 10;
  localparam int GT  = 3;
  localparam int RN  = 2;
  localparam int WT  = 2;

  logic        pclk = 1'b0;
  logic        rst_n = 1'b1;
  logic        play = 1'b0, uart = 1'b0, stop = 1'b0, hit = 1'b0, pause = 1'b0;
  logic [11:0] c_play = 12'h111, c_wait = 12'h222, c_game = 12'h333;
  logic [11:0] c_pause = 12'h444, c_score = 12'h555;

  logic [2:0]  state;
  logic [10:0] btn_hstart, btn_vstart, btn_hlength, btn_vlength;
  logic        btn_active, game_over;
  logic [11:0] rgb_out;
  logic [7:0]  time_left;
  logic [3:0]  round;
  logic [15:0] score;

  logic        s_play = 1'b0, s_uart = 1'b0, s_hit = 1'b0;
  logic        s_zero = 1'b0;
  logic [2:0]  s_state;
  logic [10:0] s_hs, s_vs, s_hl, s_vl;
  logic        s_btn_active, s_game_over;
  logic [11:0] s_rgb;
  logic [7:0]  s_time_left;
  logic [3:0]  s_round;
  logic [15:0] s_score;

  int n_pass = 0;
  int n_total = 0;
  bit done = 1'b0;

  always #5 pclk = ~pclk;

  game_flow_ctrl #(.CLK_HZ(CLK), .GAME_TIME(GT), .ROUNDS(RN), .WAIT_TIMEOUT(WT)) dut (
    .pclk(pclk), .rst_n(rst_n),
    .rect_clicked_play(play), .uart_start(uart), .mouse_clicked_stop(stop),
    .duck_hit(hit), .pause_toggle(pause),
    .rgb_in_play(c_play), .rgb_in_wait(c_wait), .rgb_in_game(c_game),
    .rgb_in_pause(c_pause), .rgb_in_score(c_score),
    .state(state), .btn_hstart(btn_hstart), .btn_vstart(btn_vstart),
    .btn_hlength(btn_hlength), .btn_vlength(btn_vlength), .btn_active(btn_active),
    .rgb_out(rgb_out), .time_left(time_left), .round(round), .score(score),
    .game_over(game_over)
  );

  game_flow_ctrl #(.CLK_HZ(300), .GAME_TIME(255), .ROUNDS(1), .WAIT_TIMEOUT(0)) dut_sat (
    .pclk(pclk), .rst_n(rst_n),
    .rect_clicked_play(s_play), .uart_start(s_uart), .mouse_clicked_stop(s_zero),
    .duck_hit(s_hit), .pause_toggle(s_zero),
    .rgb_in_play(c_play), .rgb_in_wait(c_wait), .rgb_in_game(c_game),
    .rgb_in_pause(c_pause), .rgb_in_score(c_score),
    .state(s_state), .btn_hstart(s_hs), .btn_vstart(s_vs),
    .btn_hlength(s_hl), .btn_vlength(s_vl), .btn_active(s_btn_active),
    .rgb_out(s_rgb), .time_left(s_time_left), .round(s_round), .score(s_score),
    .game_over(s_game_over)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    else n_pass++;
  endtask

  // ---------------- behavioural model ----------------
  int m_state, m_round, m_score, m_tl, m_go, m_rgb, m_btn;
  int m_elapsed, m_wait;

  function automatic int color(input int s);
    case (s)
      0: return 32'h111;
      1: return 32'h222;
      2: return 32'h333;
      3: return 32'h444;
      4: return 32'h555;
      default: return 0;
    endcase
  endfunction

  task automatic m_reset();
    m_state = 0; m_round = 0; m_score = 0; m_tl = 0; m_go = 0;
    m_rgb = 0; m_btn = 1; m_elapsed = 0; m_wait = 0;
  endtask

  task automatic m_step();
    int nxt;
    nxt = m_state;
    m_go = 0;
    case (m_state)
      0: if (play) begin nxt = 1; m_score = 0; m_round = 0; m_wait = 0; end
      1: begin
        m_wait++;
        if (play && uart) begin nxt = 2; m_elapsed = 0; m_tl = GT; end
        else if (WT != 0 && m_wait == WT * CLK) nxt = 0;
      end
      2: begin
        if (hit && m_score < 65535) m_score++;
        m_elapsed++;
        m_tl = GT - m_elapsed / CLK;
        if (m_elapsed == GT * CLK) begin
          m_tl = 0;
          if (m_round == RN - 1) begin nxt = 4; m_go = 1; end
          else begin m_round++; nxt = 1; m_wait = 0; end
        end else if (pause) nxt = 3;
      end
      3: if (pause) nxt = 2;
      4: if (stop) nxt = 0;
      default: nxt = 0;
    endcase
    m_rgb = color(m_state);
    m_btn = (nxt == 0) ? 1 : 0;
    m_state = nxt;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge pclk or negedge rst_n);
      if (!rst_n) m_reset();
      else m_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge pclk);
      if (!done) begin
        chk("state", int'(state), m_state);
        chk("time_left", int'(time_left), m_tl);
        chk("round", int'(round), m_round);
        chk("score", int'(score), m_score);
        chk("game_over", int'(game_over), m_go);
        chk("rgb_out", int'(rgb_out), m_rgb);
        chk("btn_active", int'(btn_active), m_btn);
        chk("btn_hstart", int'(btn_hstart), m_btn ? 380 : 0);
        chk("btn_vstart", int'(btn_vstart), m_btn ? 186 : 0);
        chk("btn_hlength", int'(btn_hlength), m_btn ? 300 : 0);
        chk("btn_vlength", int'(btn_vlength), m_btn ? 100 : 0);
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge pclk);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    #1 rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
    chk("rst_state", int'(state), 0);
    chk("rst_btn_hstart", int'(btn_hstart), 380);
    chk("rst_btn_active", int'(btn_active), 1);
    chk("rst_rgb", int'(rgb_out), 0);
    chk("rst_time_left", int'(time_left), 0);
    step();

    // Round 0
    play = 1; step(); play = 0;
    chk("idle_to_wait", int'(state), 1);
    step(3);
    play = 1; uart = 1; step(); play = 0; uart = 0;
    chk("wait_to_game", int'(state), 2);
    chk("game_time_left", int'(time_left), 3);
    chk("game_btn_active", int'(btn_active), 0);
    repeat (5) begin hit = 1; step(); hit = 0; step(); end
    chk("first_decrement", int'(time_left), 2);
    step(19);
    chk("tl_before_end", int'(time_left), 1);
    step();
    chk("round_end_state", int'(state), 1);
    chk("round_end_round", int'(round), 1);
    chk("round_end_tl", int'(time_left), 0);
    chk("score_5", int'(score), 5);

    // Round 1 with pause
    step(2);
    play = 1; uart = 1; step(); play = 0; uart = 0;
    chk("r1_tl", int'(time_left), 3);
    step(11);
    pause = 1; step(); pause = 0;
    chk("paused", int'(state), 3);
    chk("paused_tl", int'(time_left), 2);
    repeat (3) begin hit = 1; step(); hit = 0; step(); end
    step(43);
    chk("pause_hold_tl", int'(time_left), 2);
    chk("pause_hits_ignored", int'(score), 5);
    chk("pause_hold_state", int'(state), 3);
    pause = 1; step(); pause = 0;
    chk("resumed", int'(state), 2);
    step(7);
    chk("resume_tl_r7", int'(time_left), 2);
    step();
    chk("resume_tl_r8", int'(time_left), 1);
    step(9);
    chk("resume_tl_r17", int'(time_left), 1);
    hit = 1; pause = 1; step(); hit = 0; pause = 0;
    chk("final_state", int'(state), 4);
    chk("game_over_pulse", int'(game_over), 1);
    chk("final_tick_hit", int'(score), 6);
    chk("final_tl", int'(time_left), 0);
    step();
    chk("game_over_low", int'(game_over), 0);
    stop = 1; step(); stop = 0;
    chk("score_to_idle", int'(state), 0);
    chk("score_retained", int'(score), 6);
    chk("round_retained", int'(round), 1);

    // WAIT timeout
    play = 1; step(); play = 0;
    chk("wait_score_clr", int'(score), 0);
    chk("wait_round_clr", int'(round), 0);
    step(19);
    chk("wait_19", int'(state), 1);
    step();
    chk("wait_timeout", int'(state), 0);

    // Start coincident with timeout tick
    play = 1; step(); play = 0;
    step(19);
    play = 1; uart = 1; step(); play = 0; uart = 0;
    chk("start_beats_timeout", int'(state), 2);

    // Pause coincident with round-ending tick (not last round)
    step(29);
    chk("prio_tl", int'(time_left), 1);
    pause = 1; step(); pause = 0;
    chk("prio_wait", int'(state), 1);
    chk("prio_round", int'(round), 1);
    step();
    chk("prio_stays_wait", int'(state), 1);

    // Asynchronous reset mid-GAME
    play = 1; uart = 1; step(); play = 0; uart = 0;
    hit = 1; step(); hit = 0;
    chk("pre_reset_score", int'(score), 1);
    step(3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_state", int'(state), 0);
    chk("async_btn_hstart", int'(btn_hstart), 380);
    chk("async_btn_active", int'(btn_active), 1);
    chk("async_score", int'(score), 0);
    chk("async_tl", int'(time_left), 0);
    step(2);
    rst_n = 1'b1;
    step();
    chk("post_reset_rgb", int'(rgb_out), 32'h111);

    // Second instance: WAIT without timeout, then score saturation
    s_play = 1; step(); s_play = 0;
    chk("sat_wait", int'(s_state), 1);
    step(500);
    chk("sat_wait_500", int'(s_state), 1);
    step(500);
    chk("sat_wait_1000", int'(s_state), 1);
    s_play = 1; s_uart = 1; step(); s_play = 0; s_uart = 0;
    chk("sat_game", int'(s_state), 2);
    chk("sat_tl", int'(s_time_left), 255);
    s_hit = 1;
    step(65535);
    chk("sat_reach_max", int'(s_score), 65535);
    step(5);
    s_hit = 0;
    chk("sat_hold_max", int'(s_score), 65535);
    chk("sat_still_game", int'(s_state), 2);
    chk("sat_tl_later", int'(s_time_left), 37);

    done = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
